// File: rtl/debounce_sync.sv
// debounce_sync: brings a raw asynchronous level into the clk domain, rejects bounce,
// and presents a registered clean level with one-cycle rise/fall strobes.
module debounce_sync #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic q_clean,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    STABLE_LO  = 2'd0,
    CONFIRM_HI = 2'd1,
    STABLE_HI  = 2'd2,
    CONFIRM_LO = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] sync_next;
  logic                   s;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             q_clean_reg, q_clean_next;
  logic             rise_reg, rise_next;
  logic             fall_reg, fall_next;
  logic             busy_reg, busy_next;

  // Synchroniser chain: stage 0 captures d_in, each later stage copies its predecessor.
  assign sync_next[0] = d_in;
  for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
    assign sync_next[gi] = sync_reg[gi-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= sync_next;
    end
  end

  assign s = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= STABLE_LO;
      cnt_reg     <= '0;
      q_clean_reg <= 1'b0;
      rise_reg    <= 1'b0;
      fall_reg    <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      q_clean_reg <= q_clean_next;
      rise_reg    <= rise_next;
      fall_reg    <= fall_next;
      busy_reg    <= busy_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    q_clean_next = q_clean_reg;
    rise_next    = 1'b0;
    fall_next    = 1'b0;
    case (state_reg)
      STABLE_LO: begin
        cnt_next = '0;
        if (s) state_next = CONFIRM_HI;
      end
      CONFIRM_HI: begin
        if (!s) begin
          state_next = STABLE_LO;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next   = STABLE_HI;
          cnt_next     = '0;
          q_clean_next = 1'b1;
          rise_next    = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      STABLE_HI: begin
        cnt_next = '0;
        if (!s) state_next = CONFIRM_LO;
      end
      CONFIRM_LO: begin
        if (s) begin
          state_next = STABLE_HI;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next   = STABLE_LO;
          cnt_next     = '0;
          q_clean_next = 1'b0;
          fall_next    = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next   = STABLE_LO;
        cnt_next     = '0;
        q_clean_next = 1'b0;
      end
    endcase
    // busy is registered from the next state so it lines up with the state register.
    busy_next = (state_next == CONFIRM_HI) || (state_next == CONFIRM_LO);
  end

  assign q_clean = q_clean_reg;
  assign rise    = rise_reg;
  assign fall    = fall_reg;
  assign busy    = busy_reg;

endmodule
